riscv_fetch_unit: RTL and testbench
===================================

Name: riscv_fetch_unit

Overview:
Parametrised instruction-fetch front end for the 5-stage RISC-V pipeline. It replaces the bare IF register stage with a PC generator, a request/response interface to instruction memory that allows multiple reads in flight, and an instruction queue of FETCH_DEPTH entries. The queue feeds ID through a valid/ready handshake. A redirect from EX flushes the queue and discards stale in-flight responses.

Parameters:
XLEN, 32, data/address width
PC_INITIAL, 32'h0040_0000, PC after reset
FETCH_DEPTH, 4, instruction queue entries (power of 2, >=2)
MAX_OUTSTANDING, 2, max imem reads in flight (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, synchronous, active-low (rst==0 resets)
imem_req  output  1  read request valid
imem_addr  output  XLEN  read address (word aligned)
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  read data valid; responses return in request order
imem_rdata  input  32  instruction word
id_valid  output  1  queue head valid toward ID
id_instr  output  32  head instruction
id_pc  output  XLEN  head PC
id_ready  input  1  ID accepts head
redirect_valid  input  1  branch/jump taken, flush
redirect_pc  input  XLEN  new fetch PC; bits[1:0] forced to 0

Behaviour:
- Reset (rst==0 at a clock edge):
  - pc_q=PC_INITIAL, resp_pc=PC_INITIAL.
  - queue empty; outstanding=0, discard=0.
  - Outputs: imem_req=0, id_valid=0, id_instr=0, id_pc=0. imem_addr follows pc_q.
  - Reset mid-operation drops all queued and in-flight instructions. Responses arriving after reset while discard==0 are ignored (see fault rule).
- Credit: live = outstanding - discard.
  - imem_req = rst && !redirect_valid && (count + live < FETCH_DEPTH) && (outstanding < MAX_OUTSTANDING).
- Issue: imem_addr = pc_q. When imem_req && imem_gnt: pc_q += 4 (wraps modulo 2^XLEN) and outstanding++.
- Response: when imem_rvalid, outstanding--.
  - If discard>0: discard-- and the word is dropped.
  - Otherwise push {resp_pc, imem_rdata} to the queue, then resp_pc += 4.
  - The credit rule guarantees a push never finds the queue full.
- Fault: imem_rvalid while outstanding==0 is ignored; no counter underflows.
- Pop: id_valid = (count>0) && !redirect_valid. On id_valid && id_ready, the head is removed.
- Push and pop in the same cycle leave count unchanged; both pointers advance and wrap modulo FETCH_DEPTH.
- Latency: grant at cycle t, rvalid at t+1 gives id_valid at t+2. With constant ready and a 1-cycle memory, throughput is 1 instruction/cycle once MAX_OUTSTANDING >= 2.
- Redirect (redirect_valid=1), all in the same cycle:
  - queue cleared, pc_q and resp_pc set to {redirect_pc[XLEN-1:2],2'b00};
  - no request issued, no pop, any response this cycle dropped;
  - discard <= outstanding - (imem_rvalid ? 1 : 0).
  - Fetch resumes the next cycle.
  - Back-to-back redirects: the last one wins; discard is recomputed each cycle.
- id_instr/id_pc read the head entry and are held stable while id_valid && !id_ready.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs perf_fetched (32 bits, counts pushes), perf_flushed (32 bits, counts redirect cycles) and perf_dropped (32 bits, counts discarded responses). All reset to 0 and wrap.
- Not defined: these ports and their counters do not exist.

Test Plan:
- Reset release, 1-cycle memory, id_ready=1 -> addresses 0x00400000, 0x00400004, 0x00400008 issued back-to-back; first id_valid 2 cycles after first grant with id_pc=0x00400000.
- id_ready=0 for 20 cycles, FETCH_DEPTH=4 -> exactly 4 grants; imem_req low thereafter; head id_pc=0x00400000 stable; release -> 4 in-order pops, then fetch resumes at 0x00400010.
- 3-cycle memory latency with 2 reads in flight, redirect_pc=0x00401002 -> both stale responses dropped; next id_pc=0x00401000 and next imem_addr=0x00401000.
- Redirect in the same cycle as imem_rvalid and id_ready -> no pop, response dropped, discard = outstanding-1, id_valid low that cycle.
- rst low for one cycle mid-stream with a full queue -> id_valid=0 and imem_req=0 next cycle; refetch from 0x00400000; stray rvalid with outstanding==0 ignored.
- imem_gnt held low 10 cycles -> imem_addr held at pc_q, imem_req held high; no queue change.

Source files
------------

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: PC generator, pipelined imem read port, in-order instruction queue to ID.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module riscv_fetch_unit #(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] PC_INITIAL      = XLEN'(32'h0040_0000),
    parameter int              FETCH_DEPTH     = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            id_valid,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    input  logic            id_ready,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed,
    output logic [31:0]     perf_dropped,
`endif
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int AW = $clog2(FETCH_DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [XLEN-1:0] pc_q, resp_pc;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [OW-1:0]   outstanding, discard;

    logic [XLEN-1:0] q_pc    [FETCH_DEPTH];
    logic [31:0]     q_instr [FETCH_DEPTH];

    logic            resp_ok, push, pop, issue;
    logic [31:0]     in_use;
    logic [XLEN-1:0] target;
    logic            unused_pc_bits;

    assign target         = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_pc_bits = ^redirect_pc[1:0];

    // Queue slots already spoken for: occupied entries plus live (non-discarded) reads in flight.
    assign in_use    = 32'(count) + 32'(outstanding) - 32'(discard);
    assign imem_req  = rst && !redirect_valid && (in_use < 32'(FETCH_DEPTH))
                       && (32'(outstanding) < 32'(MAX_OUTSTANDING));
    assign imem_addr = pc_q;
    assign issue     = imem_req && imem_gnt;

    // A response with nothing outstanding is a protocol fault and is ignored.
    assign resp_ok   = imem_rvalid && (outstanding != '0);
    assign push      = rst && resp_ok && (discard == '0) && !redirect_valid;

    assign id_valid  = (count != '0) && !redirect_valid;
    assign pop       = id_valid && id_ready;
    assign id_instr  = (count != '0) ? q_instr[rd_ptr] : '0;
    assign id_pc     = (count != '0) ? q_pc[rd_ptr]    : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= resp_pc;
            q_instr[wr_ptr] <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q        <= PC_INITIAL;
            resp_pc     <= PC_INITIAL;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect_valid) begin
            // Every read still in flight after this cycle belongs to the old path.
            pc_q        <= target;
            resp_pc     <= target;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= outstanding - OW'(resp_ok);
            discard     <= outstanding - OW'(resp_ok);
        end else begin
            if (issue)
                pc_q <= pc_q + XLEN'(4);
            outstanding <= outstanding + OW'(issue) - OW'(resp_ok);
            if (resp_ok && discard != '0)
                discard <= discard - OW'(1);
            if (push) begin
                wr_ptr  <= wr_ptr + AW'(1);
                resp_pc <= resp_pc + XLEN'(4);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
            perf_dropped <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(push);
            perf_flushed <= perf_flushed + 32'(redirect_valid);
            perf_dropped <= perf_dropped + 32'(resp_ok && (redirect_valid || discard != '0));
        end
    end
`endif

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit: in-order imem model with variable latency plus a PC/instruction scoreboard.
module tb_riscv_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    riscv_fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] sb[$];
    logic [31:0] issued[$];
    int          issued_cyc[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    bit gnt_en = 0;
    bit force_rvalid = 0;
    bit lat_arm = 0;
    int first_vld_cyc = -1;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: acts #1 after each falling edge, once the stimulus has settled.
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (!rst) begin
                pend.delete();
                imem_rvalid = 1'b0;
                imem_gnt    = 1'b0;
            end else begin
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = word_at(pend[0].addr);
                    void'(pend.pop_front());
                end else if (force_rvalid) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = 32'hDEAD_BEEF;
                end else begin
                    imem_rvalid = 1'b0;
                end
                imem_gnt = gnt_en;
                if (imem_req && gnt_en) begin
                    pend.push_back('{addr: imem_addr, due: cyc + lat});
                    issued.push_back(imem_addr);
                    issued_cyc.push_back(cyc);
                end
            end
        end
    end

    // Monitor: compares every accepted ID handshake against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (lat_arm && id_valid && first_vld_cyc < 0)
                first_vld_cyc = cyc;
            if (id_valid && id_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got pc %h, expected no instruction", id_pc);
                end else begin
                    logic [31:0] e;
                    e = sb.pop_front();
                    chk("pop_pc", id_pc, e);
                    chk("pop_instr", id_instr, word_at(e));
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #3;
            if (sb.size() == 0 && pend.size() == 0 && !id_valid) begin
                done = 1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expectations, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic clear_log();
        issued.delete();
        issued_cyc.delete();
    endtask

    initial begin
        rst = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

        // Reset state and back-to-back fetch with a 1-cycle memory
        tick(); #3;
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_instr", id_instr, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0040_0000);
        tick();
        clear_log();
        rst = 1'b1; lat = 1; gnt_en = 1; id_ready = 1; lat_arm = 1;
        for (int i = 0; i < 6; i++) sb.push_back(32'h0040_0000 + 32'(4 * i));
        tick(6);
        gnt_en = 0;
        drain();
        lat_arm = 0;
        chk("t1_grants", 32'(issued.size()), 32'd6);
        if (issued.size() >= 3) begin
            chk("t1_addr0", issued[0], 32'h0040_0000);
            chk("t1_addr1", issued[1], 32'h0040_0004);
            chk("t1_addr2", issued[2], 32'h0040_0008);
            chk("t1_b2b", 32'(issued_cyc[2] - issued_cyc[0]), 32'd2);
            chk("t1_latency", 32'(first_vld_cyc - issued_cyc[0]), 32'd2);
        end

        // Backpressure: the queue fills after exactly FETCH_DEPTH grants
        tick(); rst = 1'b0;
        tick(); rst = 1'b1; id_ready = 0; gnt_en = 1;
        clear_log();
        tick(5); #3;
        chk("t2_head_early", id_pc, 32'h0040_0000);
        tick(15); #3;
        chk("t2_grants", 32'(issued.size()), 32'd4);
        chk("t2_req_low", 32'(imem_req), 32'd0);
        chk("t2_valid", 32'(id_valid), 32'd1);
        chk("t2_head_late", id_pc, 32'h0040_0000);
        for (int i = 0; i < 4; i++) sb.push_back(32'h0040_0000 + 32'(4 * i));
        tick(); id_ready = 1; gnt_en = 0;
        drain();
        chk("t2_resume_addr", imem_addr, 32'h0040_0010);
        chk("t2_resume_req", 32'(imem_req), 32'd1);

        // Redirect with two slow reads in flight
        tick(); lat = 3; gnt_en = 1;
        clear_log();
        tick(2);
        redirect_valid = 1; redirect_pc = 32'h0040_1002; gnt_en = 0;
        #3;
        chk("t3_redir_req", 32'(imem_req), 32'd0);
        chk("t3_redir_valid", 32'(id_valid), 32'd0);
        chk("t3_inflight", 32'(issued.size()), 32'd2);
        tick(); redirect_valid = 0;
        #3;
        chk("t3_new_addr", imem_addr, 32'h0040_1000);
        drain();
        chk("t3_req_after", 32'(imem_req), 32'd1);
        chk("t3_addr_after", imem_addr, 32'h0040_1000);
        sb.push_back(32'h0040_1000);
        tick(); gnt_en = 1;
        tick(); gnt_en = 0;
        drain();

        // Redirect coinciding with a response and a ready ID stage
        tick(); lat = 3; id_ready = 0; gnt_en = 1;
        clear_log();
        tick(6); #3;
        chk("t4_head_valid", 32'(id_valid), 32'd1);
        chk("t4_head_pc", id_pc, 32'h0040_1004);
        tick();
        redirect_valid = 1; redirect_pc = 32'h0040_2000; id_ready = 1; gnt_en = 0;
        #3;
        chk("t4_redir_valid", 32'(id_valid), 32'd0);
        chk("t4_redir_req", 32'(imem_req), 32'd0);
        chk("t4_redir_rvalid_cycle", 32'(imem_rvalid && issued.size() == 4), 32'd1);
        tick(); redirect_valid = 0;
        #3;
        chk("t4_req_one_stale", 32'(imem_req), 32'd1);
        chk("t4_addr", imem_addr, 32'h0040_2000);
        drain();

        // Reset mid-stream with a full queue, then a stray response
        tick(); lat = 1; id_ready = 0; gnt_en = 1;
        tick(8); #3;
        chk("t5_full_valid", 32'(id_valid), 32'd1);
        chk("t5_full_req", 32'(imem_req), 32'd0);
        tick(); rst = 1'b0; gnt_en = 0;
        #3;
        chk("t5_rst_req", 32'(imem_req), 32'd0);
        tick(); rst = 1'b1;
        #3;
        chk("t5_post_valid", 32'(id_valid), 32'd0);
        chk("t5_post_pc", id_pc, 32'd0);
        chk("t5_post_instr", id_instr, 32'd0);
        chk("t5_post_addr", imem_addr, 32'h0040_0000);
        tick(); force_rvalid = 1;
        tick(); force_rvalid = 0;
        #3;
        chk("t5_stray_valid", 32'(id_valid), 32'd0);
        chk("t5_stray_req", 32'(imem_req), 32'd1);
        clear_log();
        sb.push_back(32'h0040_0000);
        sb.push_back(32'h0040_0004);
        tick(); id_ready = 1; gnt_en = 1;
        tick(2); gnt_en = 0;
        drain();
        chk("t5_refetch_cnt", 32'(issued.size()), 32'd2);
        if (issued.size() > 0) chk("t5_refetch_addr", issued[0], 32'h0040_0000);

        // Grant withheld: request and address must hold
        for (int i = 0; i < 10; i++) begin
            tick(); #3;
            chk("t6_req_held", 32'(imem_req), 32'd1);
            chk("t6_addr_held", imem_addr, 32'h0040_0008);
            chk("t6_no_valid", 32'(id_valid), 32'd0);
        end
        sb.push_back(32'h0040_0008);
        tick(); gnt_en = 1;
        tick(); gnt_en = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
